// File: rtl/ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ex_operand_stage_pkg
// Purpose : Shared configuration for the ID/EX operand stage. Holds the
//           datapath widths, the ALU opcode encodings, the forwarding-source
//           enumeration and the packed ID/EX payload record.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ex_operand_stage_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ALU_OP_WIDTH   = 6;

    // ALU opcode encodings shared with the ALU.
    localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_ADD  = 6'h00;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SUB  = 6'h01;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_AND  = 6'h02;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_OR   = 6'h03;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_XOR  = 6'h04;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SLL  = 6'h05;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SRL  = 6'h06;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SRA  = 6'h07;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SLT  = 6'h08;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ALU_SLTU = 6'h09;

    // Where a source operand value was taken from.
    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // Everything the stage registers for one decoded instruction.
    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rs1_addr;
        logic [REG_ADDR_WIDTH-1:0] rs2_addr;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0]     rs1_data;
        logic [DATA_WIDTH-1:0]     rs2_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [DATA_WIDTH-1:0]     pc;
        logic [ALU_OP_WIDTH-1:0]   alu_op;
        logic                      uses_rs1;
        logic                      uses_rs2;
        logic                      use_imm;
        logic                      use_pc;
        logic                      reg_write;
    } id_ex_payload_t;

    // Reset image of the payload: all zero except a harmless ADD opcode.
    function automatic id_ex_payload_t payload_reset_value();
        id_ex_payload_t p;
        p        = '0;
        p.alu_op = OP_ALU_ADD;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_operand_stage_operand_forward.sv
`default_nettype none
// ============================================================================
// Module  : operand_forward
// Purpose : Resolves one source operand against the EX/MEM and MEM/WB bypass
//           buses. EX/MEM (younger) wins over MEM/WB; register x0 is never
//           forwarded.
// Ports   : rs_addr_i/rs_data_i          - held source index and regfile value
//           exmem_wen_i/rd_i/data_i      - EX/MEM bypass bus
//           memwb_wen_i/rd_i/data_i      - MEM/WB bypass bus
//           fwd_data_o                   - resolved operand value
//           fwd_sel_o                    - which source supplied the value
// Revision: 1.0 - initial release
// ============================================================================
module operand_forward #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
    input  logic [DATA_WIDTH-1:0]     rs_data_i,
    input  logic                      exmem_wen_i,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
    input  logic [DATA_WIDTH-1:0]     exmem_data_i,
    input  logic                      memwb_wen_i,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
    input  logic [DATA_WIDTH-1:0]     memwb_data_i,
    output logic [DATA_WIDTH-1:0]     fwd_data_o,
    output ex_operand_stage_pkg::fwd_sel_e fwd_sel_o
);
    import ex_operand_stage_pkg::*;

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = exmem_wen_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_i);
    assign w_memwb_hit = memwb_wen_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_i);

    always_comb begin
        fwd_sel_o  = FWD_RF;
        fwd_data_o = rs_data_i;
        if (w_exmem_hit) begin
            fwd_sel_o  = FWD_EXMEM;
            fwd_data_o = exmem_data_i;
        end else if (w_memwb_hit) begin
            fwd_sel_o  = FWD_MEMWB;
            fwd_data_o = memwb_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module  : ex_operand_stage
// Purpose : ID/EX pipeline register in front of the ALU. Captures a decoded
//           instruction over a valid/ready handshake, forwards operands from
//           EX/MEM and MEM/WB, stalls on load-use hazards and drives the ALU
//           operands plus writeback/store sideband.
// Ports   : clk_i, rst_ni                - clock, async active-low reset
//           in_valid_i/in_ready_o        - upstream handshake
//           rs*/uses_rs*/imm/pc/alu_op/use_*/rd/reg_write_i - decoded payload
//           flush_i                      - kill held and incoming instruction
//           exmem_*_i, memwb_*_i         - bypass buses
//           out_valid_o/out_ready_i      - downstream handshake
//           a_o, b_o, alu_op_o           - ALU operands and opcode
//           store_data_o, rd_addr_o, reg_write_o, pc_o - sideband
// Revision: 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
    parameter int DATA_WIDTH     = ex_operand_stage_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = ex_operand_stage_pkg::REG_ADDR_WIDTH,
    parameter int ALU_OP_WIDTH   = ex_operand_stage_pkg::ALU_OP_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic                      uses_rs1_i,
    input  logic                      uses_rs2_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [DATA_WIDTH-1:0]     imm_i,
    input  logic [DATA_WIDTH-1:0]     pc_i,
    input  logic [ALU_OP_WIDTH-1:0]   alu_op_i,
    input  logic                      use_imm_i,
    input  logic                      use_pc_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                      reg_write_i,
    input  logic                      flush_i,
    input  logic                      exmem_wen_i,
    input  logic                      exmem_is_load_i,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
    input  logic [DATA_WIDTH-1:0]     exmem_data_i,
    input  logic                      memwb_wen_i,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
    input  logic [DATA_WIDTH-1:0]     memwb_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     a_o,
    output logic [DATA_WIDTH-1:0]     b_o,
    output logic [ALU_OP_WIDTH-1:0]   alu_op_o,
    output logic [DATA_WIDTH-1:0]     store_data_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                      reg_write_o,
    output logic [DATA_WIDTH-1:0]     pc_o
);
    import ex_operand_stage_pkg::*;

    id_ex_payload_t        r_payload;
    id_ex_payload_t        w_payload_in;
    logic                  r_valid;

    logic [DATA_WIDTH-1:0] w_rs1_fwd;
    logic [DATA_WIDTH-1:0] w_rs2_fwd;
    fwd_sel_e              w_rs1_sel;
    fwd_sel_e              w_rs2_sel;

    logic                  w_hazard;
    logic                  w_fire_out;
    logic                  w_accept;

    assign w_payload_in = '{
        rs1_addr:  rs1_addr_i,
        rs2_addr:  rs2_addr_i,
        rd_addr:   rd_addr_i,
        rs1_data:  rs1_data_i,
        rs2_data:  rs2_data_i,
        imm:       imm_i,
        pc:        pc_i,
        alu_op:    alu_op_i,
        uses_rs1:  uses_rs1_i,
        uses_rs2:  uses_rs2_i,
        use_imm:   use_imm_i,
        use_pc:    use_pc_i,
        reg_write: reg_write_i
    };

    // ------------------------------------------------------------------
    // Operand forwarding for both sources
    // ------------------------------------------------------------------
    operand_forward #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .rs_addr_i    (r_payload.rs1_addr),
        .rs_data_i    (r_payload.rs1_data),
        .exmem_wen_i  (exmem_wen_i),
        .exmem_rd_i   (exmem_rd_i),
        .exmem_data_i (exmem_data_i),
        .memwb_wen_i  (memwb_wen_i),
        .memwb_rd_i   (memwb_rd_i),
        .memwb_data_i (memwb_data_i),
        .fwd_data_o   (w_rs1_fwd),
        .fwd_sel_o    (w_rs1_sel)
    );

    operand_forward #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .rs_addr_i    (r_payload.rs2_addr),
        .rs_data_i    (r_payload.rs2_data),
        .exmem_wen_i  (exmem_wen_i),
        .exmem_rd_i   (exmem_rd_i),
        .exmem_data_i (exmem_data_i),
        .memwb_wen_i  (memwb_wen_i),
        .memwb_rd_i   (memwb_rd_i),
        .memwb_data_i (memwb_data_i),
        .fwd_data_o   (w_rs2_fwd),
        .fwd_sel_o    (w_rs2_sel)
    );

    // ------------------------------------------------------------------
    // Load-use hazard: a source that would be taken from EX/MEM while that
    // stage holds a load has no value yet. The forwarding selector already
    // encodes "EX/MEM writes a non-zero rd matching this source".
    // ------------------------------------------------------------------
    assign w_hazard = r_valid && exmem_is_load_i &&
                      ((r_payload.uses_rs1 && (w_rs1_sel == FWD_EXMEM)) ||
                       (r_payload.uses_rs2 && (w_rs2_sel == FWD_EXMEM)));

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign out_valid_o = r_valid && !w_hazard;
    assign w_fire_out  = out_valid_o && out_ready_i;
    // flush_i frees the slot, but the incoming instruction is discarded.
    assign in_ready_o  = !r_valid || w_fire_out || flush_i;
    assign w_accept    = in_valid_i && in_ready_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_payload <= payload_reset_value();
        end else if (flush_i) begin
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            // Covers the simultaneous fire+accept case with no bubble.
            r_valid   <= 1'b1;
            r_payload <= w_payload_in;
        end else if (w_fire_out) begin
            r_valid   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_o          = r_payload.use_pc  ? r_payload.pc  : w_rs1_fwd;
    assign b_o          = r_payload.use_imm ? r_payload.imm : w_rs2_fwd;
    assign store_data_o = w_rs2_fwd;
    assign alu_op_o     = r_payload.alu_op;
    assign rd_addr_o    = r_payload.rd_addr;
    assign reg_write_o  = r_payload.reg_write && out_valid_o;
    assign pc_o         = r_payload.pc;

endmodule
`default_nettype wire
